// File: rtl/snake_timing_pkg.sv
// Shared timing defaults for the snake game: VGA frame pacing, tick divider and speed-up.
package snake_timing_pkg;
  localparam int DIV_W_DEFAULT      = 4;
  localparam int DIV_INIT_DEFAULT   = 2;  // 60 Hz frames -> 30 Hz moves
  localparam int DIV_MIN_DEFAULT    = 1;
  localparam int STEP_EVERY_DEFAULT = 4;
  localparam int LVL_W_DEFAULT      = 4;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction
endpackage

// File: rtl/game_tick_gen_if.sv
// Control/status bundle between the game FSM (master) and the tick generator (slave).
import snake_timing_pkg::*;

interface game_tick_gen_if #(
  parameter int DIV_W = DIV_W_DEFAULT,
  parameter int LVL_W = LVL_W_DEFAULT
);
  logic             frame_tik;
  logic             pause;
  logic             speed_reset;
  logic             apple_eaten;
  logic             game_tik;
  logic [DIV_W-1:0] frame_div;
  logic [LVL_W-1:0] speed_level;

  modport master (
    output frame_tik, pause, speed_reset, apple_eaten,
    input  game_tik, frame_div, speed_level
  );

  modport slave (
    input  frame_tik, pause, speed_reset, apple_eaten,
    output game_tik, frame_div, speed_level
  );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the history register tracks the input every cycle.
module rise_detect (
  input  logic clock_25,
  input  logic reset,
  input  logic in,
  output logic rise
);
  logic prev;

  always_ff @(posedge clock_25) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign rise = in & ~prev;
endmodule

// File: rtl/game_tick_gen.sv
// Divides VGA frame edges into game move strobes; the divisor shrinks as apples are eaten.
import snake_timing_pkg::*;

module game_tick_gen #(
  parameter int DIV_W      = DIV_W_DEFAULT,
  parameter int DIV_INIT   = DIV_INIT_DEFAULT,
  parameter int DIV_MIN    = DIV_MIN_DEFAULT,
  parameter int STEP_EVERY = STEP_EVERY_DEFAULT,
  parameter int LVL_W      = LVL_W_DEFAULT
) (
  input logic             clock_25,
  input logic             reset,
  game_tick_gen_if.slave  bus
);
  localparam int APL_W = cnt_width(STEP_EVERY);

  logic             rise;
  logic             game_tik;
  logic [DIV_W-1:0] frame_div;
  logic [DIV_W-1:0] frame_cnt;
  logic [LVL_W-1:0] speed_level;
  logic [APL_W-1:0] apple_cnt;

  rise_detect u_rise (
    .clock_25 (clock_25),
    .reset    (reset),
    .in       (bus.frame_tik),
    .rise     (rise)
  );

  always_ff @(posedge clock_25) begin
    if (reset) begin
      game_tik    <= 1'b0;
      frame_div   <= DIV_W'(DIV_INIT);
      frame_cnt   <= '0;
      speed_level <= '0;
      apple_cnt   <= '0;
    end else if (bus.speed_reset) begin
      game_tik    <= 1'b0;
      frame_div   <= DIV_W'(DIV_INIT);
      frame_cnt   <= '0;
      speed_level <= '0;
      apple_cnt   <= '0;
    end else begin
      game_tik <= 1'b0;
      if (rise && !bus.pause) begin
        if (frame_cnt == frame_div - DIV_W'(1)) begin
          frame_cnt <= '0;
          game_tik  <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + DIV_W'(1);
        end
      end
      // A divisor change restarts the frame count, overriding the increment above.
      if (bus.apple_eaten) begin
        if (apple_cnt == APL_W'(STEP_EVERY - 1)) begin
          apple_cnt <= '0;
          if (frame_div > DIV_W'(DIV_MIN)) begin
            frame_div <= frame_div - DIV_W'(1);
            frame_cnt <= '0;
            if (speed_level != '1) speed_level <= speed_level + LVL_W'(1);
          end
        end else begin
          apple_cnt <= apple_cnt + APL_W'(1);
        end
      end
    end
  end

  assign bus.game_tik    = game_tik;
  assign bus.frame_div   = frame_div;
  assign bus.speed_level = speed_level;
endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench: three dividers (DIV_INIT 2, 5, 4) share one stimulus stream.
module tb_game_tick_gen;
  logic clock_25 = 1'b0;
  logic reset = 1'b1;
  logic frame_tik = 1'b0;
  logic pause = 1'b0;
  logic speed_reset = 1'b0;
  logic apple_eaten = 1'b0;

  int tests = 0;
  int failed = 0;
  int ticks_a = 0;
  logic [2:0] t1, t2;  // game_tik of {c,b,a}, one and two cycles after a raise

  always #20 clock_25 = ~clock_25;

  game_tick_gen_if #(.DIV_W(4), .LVL_W(4)) bus_a ();
  game_tick_gen_if #(.DIV_W(4), .LVL_W(4)) bus_b ();
  game_tick_gen_if #(.DIV_W(4), .LVL_W(4)) bus_c ();

  assign bus_a.frame_tik = frame_tik;   assign bus_b.frame_tik = frame_tik;   assign bus_c.frame_tik = frame_tik;
  assign bus_a.pause = pause;           assign bus_b.pause = pause;           assign bus_c.pause = pause;
  assign bus_a.speed_reset = speed_reset; assign bus_b.speed_reset = speed_reset; assign bus_c.speed_reset = speed_reset;
  assign bus_a.apple_eaten = apple_eaten; assign bus_b.apple_eaten = apple_eaten; assign bus_c.apple_eaten = apple_eaten;

  game_tick_gen #(.DIV_W(4), .DIV_INIT(2), .DIV_MIN(1), .STEP_EVERY(4), .LVL_W(4)) dut_a (
    .clock_25(clock_25), .reset(reset), .bus(bus_a));
  game_tick_gen #(.DIV_W(4), .DIV_INIT(5), .DIV_MIN(1), .STEP_EVERY(4), .LVL_W(4)) dut_b (
    .clock_25(clock_25), .reset(reset), .bus(bus_b));
  game_tick_gen #(.DIV_W(4), .DIV_INIT(4), .DIV_MIN(1), .STEP_EVERY(4), .LVL_W(4)) dut_c (
    .clock_25(clock_25), .reset(reset), .bus(bus_c));

  always @(negedge clock_25) if (!reset && bus_a.game_tik) ticks_a++;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tik = 1'b0; pause = 1'b0; speed_reset = 1'b0; apple_eaten = 1'b0;
    repeat (2) @(negedge clock_25);
    reset = 1'b0;
    @(negedge clock_25);
  endtask

  // Raise frame_tik for hold (>=2) cycles, capture game_tik right after the rise.
  task automatic frame_rise(input int hold, input int gap);
    frame_tik = 1'b1;
    @(negedge clock_25);
    t1 = {bus_c.game_tik, bus_b.game_tik, bus_a.game_tik};
    @(negedge clock_25);
    t2 = {bus_c.game_tik, bus_b.game_tik, bus_a.game_tik};
    repeat (hold - 2) @(negedge clock_25);
    frame_tik = 1'b0;
    repeat (gap) @(negedge clock_25);
  endtask

  task automatic apple();
    apple_eaten = 1'b1;
    @(negedge clock_25);
    apple_eaten = 1'b0;
    @(negedge clock_25);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock_25);
    do_reset();
    check("rst_tik_a", bus_a.game_tik, 0);
    check("rst_div_a", bus_a.frame_div, 2);
    check("rst_div_b", bus_b.frame_div, 5);
    check("rst_div_c", bus_c.frame_div, 4);
    check("rst_lvl_a", bus_a.speed_level, 0);

    // Default divider: ten rises, tick on every second one, one cycle wide.
    ticks_a = 0;
    for (int i = 0; i < 10; i++) begin
      frame_rise(3, 97);
      check($sformatf("div2_tik_r%0d", i), t1[0], (i % 2 == 1) ? 1 : 0);
      check($sformatf("div2_width_r%0d", i), t2[0], 0);
    end
    check("div2_tick_count", ticks_a, 5);

    // Four apples: 2 -> 1, then every rise ticks; four more saturate at DIV_MIN.
    repeat (4) apple();
    check("speedup_div", bus_a.frame_div, 1);
    check("speedup_lvl", bus_a.speed_level, 1);
    for (int i = 0; i < 3; i++) begin
      frame_rise(3, 10);
      check($sformatf("div1_tik_r%0d", i), t1[0], 1);
    end
    repeat (4) apple();
    check("min_div", bus_a.frame_div, 1);
    check("min_lvl", bus_a.speed_level, 1);

    // Pause with DIV_INIT=5: count held at 3, held-high edge across release ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frame_rise(3, 10);
      check($sformatf("p_pre_r%0d", i), t1[1], 0);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame_rise(3, 10);
      check($sformatf("p_during_r%0d", i), t1[1] | t2[1], 0);
    end
    frame_tik = 1'b1;
    repeat (2) @(negedge clock_25);
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_25);
      check($sformatf("p_held_c%0d", i), bus_b.game_tik, 0);
    end
    frame_tik = 1'b0;
    repeat (5) @(negedge clock_25);
    frame_rise(3, 10);
    check("p_post_r0", t1[1], 0);
    frame_rise(3, 10);
    check("p_post_r1", t1[1], 1);

    // DIV_INIT=4: rise at frame_cnt=3 coincides with 4th apple.
    do_reset();
    repeat (3) frame_rise(3, 10);
    repeat (3) apple();
    check("coin_pre_div", bus_c.frame_div, 4);
    frame_tik = 1'b1;
    apple_eaten = 1'b1;
    @(negedge clock_25);
    apple_eaten = 1'b0;
    check("coin_tik", bus_c.game_tik, 1);
    check("coin_div", bus_c.frame_div, 3);
    @(negedge clock_25);
    frame_tik = 1'b0;
    repeat (5) @(negedge clock_25);
    for (int i = 0; i < 3; i++) begin
      frame_rise(3, 10);
      check($sformatf("coin_post_r%0d", i), t1[2], (i == 2) ? 1 : 0);
    end

    // speed_reset beats a coincident apple (4th) and rise at divisor 1.
    do_reset();
    repeat (4) apple();
    check("sr_pre_lvl", bus_a.speed_level, 1);
    repeat (3) apple();
    frame_tik = 1'b1;
    apple_eaten = 1'b1;
    speed_reset = 1'b1;
    @(negedge clock_25);
    apple_eaten = 1'b0;
    speed_reset = 1'b0;
    check("sr_tik", bus_a.game_tik, 0);
    check("sr_div", bus_a.frame_div, 2);
    check("sr_lvl", bus_a.speed_level, 0);
    @(negedge clock_25);
    frame_tik = 1'b0;
    repeat (3) @(negedge clock_25);
    repeat (3) apple();
    check("sr_apl_3", bus_a.frame_div, 2);
    apple();
    check("sr_apl_4", bus_a.frame_div, 1);

    // Reset mid-count after a speed-up, with a stray apple ignored.
    do_reset();
    frame_rise(3, 10);
    repeat (4) apple();
    frame_rise(3, 10);
    check("mid_pre_div", bus_a.frame_div, 1);
    reset = 1'b1;
    apple_eaten = 1'b1;
    @(negedge clock_25);
    apple_eaten = 1'b0;
    check("mid_rst_tik", bus_a.game_tik, 0);
    check("mid_rst_div", bus_a.frame_div, 2);
    check("mid_rst_lvl", bus_a.speed_level, 0);
    reset = 1'b0;
    @(negedge clock_25);
    frame_rise(3, 10);
    check("mid_post_r0", t1[0], 0);
    frame_rise(3, 10);
    check("mid_post_r1", t1[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
